// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// One bit per cycle, start/done handshake, abort for pipeline flush.
module alu_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     ready,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [2:0]       op_q,      op_d;
    logic [2*W-1:0]   work_q,    work_d;
    logic [W-1:0]     opb_q,     opb_d;
    logic             neg_q,     neg_d;
    logic             special_q, special_d;
    logic [W-1:0]     result_q,  result_d;

    logic [2:0]   op_in;
    logic         in_is_div, in_is_rem, a_signed, b_signed, a_neg, b_neg;
    logic         div_zero, overflow;
    logic [W-1:0] a_mag, b_mag, special_val;

    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_next, div_next, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, final_result;

    // Accept-time decode: operand magnitudes, result sign and the early-out cases.
    always_comb begin
        op_in     = Operation[2:0];
        in_is_div = op_in[2];
        in_is_rem = op_in[2] & op_in[1];
        a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
        b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg     = a_signed & SrcA[W-1];
        b_neg     = b_signed & SrcB[W-1];
        a_mag     = a_neg ? -SrcA : SrcA;
        b_mag     = b_neg ? -SrcB : SrcB;
        div_zero  = in_is_div && (SrcB == '0);
        overflow  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (SrcA == MIN_VAL) && (SrcB == '1);
        if (div_zero && !in_is_rem) begin
            special_val = '1;
        end else if (overflow && in_is_rem) begin
            special_val = '0;
        end else begin
            special_val = SrcA;
        end
    end

    // One iteration of each datapath; work_q holds {acc, multiplier} or {remainder, dividend}.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_next  = {mul_sum, work_q[W-1:1]};
        div_shift = {work_q[2*W-1:W], work_q[W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_diff[W]) begin
            div_next = {div_shift[W-1:0], work_q[W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[W-1:0], work_q[W-2:0], 1'b1};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -work_q : work_q;
        quo_fix  = neg_q ? -work_q[W-1:0] : work_q[W-1:0];
        rem_fix  = neg_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];
        case (op_q)
            OP_MUL:                      final_result = prod_fix[W-1:0];
            OP_DIV, OP_DIVU:             final_result = quo_fix;
            OP_REM, 3'd7:                final_result = rem_fix;
            default:                     final_result = prod_fix[2*W-1:W];
        endcase
        if (special_q) begin
            final_result = work_q[W-1:0];
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        work_d    = work_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        special_d = special_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    op_d      = op_in;
                    neg_d     = in_is_rem ? a_neg : (a_neg ^ b_neg);
                    count_d   = CNT_W'(W);
                    special_d = div_zero || overflow;
                    if (div_zero || overflow) begin
                        work_d  = {{W{1'b0}}, special_val};
                        opb_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        work_d  = {{W{1'b0}}, in_is_div ? a_mag : b_mag};
                        opb_d   = in_is_div ? b_mag : a_mag;
                        state_d = in_is_div ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                work_d  = (state_q == S_MUL) ? mul_next : div_next;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!abort) begin
                    result_d = final_result;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // The result is forwarded in the done cycle and registered for later reads.
    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE) && !abort;
    assign ALUResult = done ? final_result : result_q;

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            work_q    <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            work_q    <= work_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes expected results, a monitor pops on done.
module tb_alu_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [2:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        ready;
    logic        done;
    logic [31:0] ALUResult;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] cyc;
        logic [7:0]  id;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ready     (ready),
        .done      (done),
        .ALUResult (ALUResult)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expected entry.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("t%0d_result", mon_e.id), ALUResult, mon_e.value);
                check($sformatf("t%0d_done_cycle", mon_e.id), 32'(cyc), mon_e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special, input bit push,
                         input logic [7:0] id);
        exp_t e;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        Operation = ~op;
        SrcA      = 32'hDEADBEEF;
        SrcB      = 32'h0;
        if (push) begin
            e.value = exp;
            e.cyc   = 32'(cyc + (special ? 0 : 32));
            e.id    = id;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check("done_within_budget", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special, input logic [7:0] id);
        issue(op, a, b, exp, special, 1'b1, id);
        wait_done(40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, expected summary earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        Operation = 3'd0; SrcA = '0; SrcB = '0;
        step(3);
        reset = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", ALUResult, 32'd0);

        // abort in IDLE must block a same-cycle start
        Operation = 3'd5; SrcA = 32'd9; SrcB = 32'd3; start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_blocks_start", 32'(ready), 32'd1);

        // MUL with full busy window, then back-to-back operations
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b1, 8'd1);
        for (int k = 0; k <= 32; k++) begin
            check($sformatf("mul_busy_cycle%0d", k + 1), 32'(ready), 32'd0);
            step(1);
        end
        check("mul_ready_after_done", 32'(ready), 32'd1);
        check("mul_result_held", ALUResult, 32'hFFFFFFEB);
        check("mul_sb_drained", 32'(sb_q.size()), 32'd0);

        run(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 8'd2);
        run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 8'd3);
        run(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 8'd4);
        run(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 8'd5);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 8'd6);
        run(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 8'd7);
        run(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 8'd8);
        run(3'd5, 32'd100,      32'd7,        32'd14,       1'b0, 8'd9);
        run(3'd7, 32'd100,      32'd7,        32'd2,        1'b0, 8'd10);
        run(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 8'd11);
        run(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 8'd12);
        run(3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 8'd13);
        run(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 8'd14);
        run(3'd7, 32'd5,        32'd0,        32'd5,        1'b1, 8'd15);
        run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 8'd16);
        run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 8'd17);

        // second start while busy is ignored
        issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1, 8'd20);
        step(4);
        Operation = 3'd5; SrcA = 32'd9; SrcB = 32'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(40);

        // abort mid-multiply: no done pulse, result register untouched
        issue(3'd0, 32'd100, 32'd200, 32'd0, 1'b0, 1'b0, 8'd0);
        step(9);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result_held", ALUResult, 32'd15);
        step(40);
        run(3'd5, 32'd9, 32'd3, 32'd3, 1'b0, 8'd21);

        // synchronous reset mid-divide
        issue(3'd4, 32'd1000, 32'd10, 32'd0, 1'b0, 1'b0, 8'd0);
        step(11);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midreset_ready", 32'(ready), 32'd1);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", ALUResult, 32'd0);
        step(40);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multi-cycle arithmetic unit executing the RV32M multiply/divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage; the pipeline stalls on ready=0 while an operation iterates.
- Shift-add multiplier and restoring divider, one bit per cycle, with start/done handshake and abort for pipeline flush.

Parameters:
- DATA_WIDTH, 32, operand and result width (>=4, even).
- OPCODE_LENGTH, 3, width of Operation; encoding equals RV32M funct3.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request; accepted only when ready=1.
- abort  input  1  flush; cancels any in-flight operation.
- Operation  input  OPCODE_LENGTH  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SrcA  input  DATA_WIDTH  rs1 (multiplicand / dividend).
- SrcB  input  DATA_WIDTH  rs2 (multiplier / divisor).
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; ALUResult valid from this cycle.
- ALUResult  output  DATA_WIDTH  result register; holds until the next done.

Behaviour:
- Reset (sync, any state): state=IDLE, ready=1, done=0, ALUResult=0, iteration counter=0, internal regs=0. Reset overrides abort and start.
- States:
  - IDLE: ready=1. start=1 and abort=0 latches Operation and operands.
    - Special cases go to DONE: divisor==0, or signed overflow (DIV/REM with SrcA=MIN, SrcB=-1).
    - Otherwise MUL ops go to MUL, divide ops go to DIV; counter=DATA_WIDTH.
  - MUL/DIV: one iteration per cycle, counter decrements; at counter==1 the next state is DONE.
  - DONE: writes ALUResult, done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge N gives done high in cycle N+DATA_WIDTH+1. Special cases give done in cycle N+1. Back-to-back start is possible in the cycle after done.
- Operand sign handling:
  - Signed operands are converted to magnitudes at accept; result sign is applied in DONE.
  - MULH treats both operands as signed; MULHSU treats SrcA as signed and SrcB as unsigned; MULHU treats both as unsigned.
  - The product is 2*DATA_WIDTH bits. MUL returns the low half; MULH* return the high half.
- Divide semantics: quotient truncates toward zero; remainder sign follows the dividend.
- Divide by zero: DIV and DIVU give all-ones; REM and REMU give SrcA.
- Overflow: DIV gives MIN; REM gives 0.
- Handshake corner cases:
  - start while ready=0 is ignored, with no queuing.
  - abort in MUL, DIV or DONE forces IDLE next cycle with no done pulse; ALUResult keeps its prior value.
  - abort in IDLE blocks a same-cycle start.
- Operand inputs are sampled only at accept; later changes have no effect.

Test Plan (DATA_WIDTH=32):
- MUL: SrcA=7, SrcB=0xFFFFFFFD, start at edge 0 -> done in cycle 33, ALUResult=0xFFFFFFEB, ready=0 during cycles 1..33.
- High-half products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- Division:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - Each gives done at cycle 33.
- Specials:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - Each gives done in cycle 1.
- Handshake:
  - Second start at cycle 5 of a MUL is ignored; first result is correct.
  - abort at cycle 10 -> ready=1 in cycle 11, no done, ALUResult unchanged.
  - A new DIVU 9/3 then yields 3.
- Reset asserted at cycle 12 of a DIV -> next cycle ready=1, done=0, ALUResult=0; no done pulse follows.
